uart_tx_cfg: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART transmitter. It serialises one character per valid/ready handshake with configurable data width, parity and stop-bit count. Parity mode and stop-bit count are runtime configuration inputs, sampled once per frame. It sits between the host-side byte producer (register bank or FIFO) and the `tx` pad, and drives a done pulse back to the producer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_cfg.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter (and the future receiver).
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;
    localparam int BIT_CNT_W     = 5;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK} parity_t;

    // Callers zero-extend narrower characters; the padding does not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input parity_t mode);
        logic p;
        case (mode)
            PAR_ODD:  p = ~^data;
            PAR_EVEN: p = ^data;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last clock of every BAUD_WIDTH-cycle period.
module uart_baud_tick #(
    parameter int BAUD_WIDTH = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BAUD_WIDTH > 1) ? $clog2(BAUD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_WIDTH - 1);

    logic [CNT_W-1:0] clk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
        end else if (clear || tick) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
        end
    end

    assign tick = (clk_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, runtime parity / stop bits).
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a handshake
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | one or two stop bits (high)
// BREAK  | line held low for two frame times (UART_TX_BREAK_EN only)
module uart_tx_cfg #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;

    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (BAUD_WIDTH < 2) begin : g_bad_baud
        $error("uart_tx_cfg: CLOCK_SPEED/BAUD_RATE must be at least 2");
    end

    tx_state_t              state, state_nxt;
    logic                   tick;
    logic                   handshake;
    logic                   last_stop;
    logic                   data_last;
    logic [DATA_BITS-1:0]   shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    parity_t                par_mode_q;
    logic                   two_stop_q;
    logic                   par_bit;

    uart_baud_tick #(.BAUD_WIDTH(BAUD_WIDTH)) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // The final stop-bit cycle already looks idle so the next frame can follow with no gap.
    assign last_stop = (state == STOP) && tick && (bit_cnt == BIT_CNT_W'(two_stop_q));
    assign data_last = (bit_cnt == BIT_CNT_W'(DATA_BITS - 1));
    assign tx_ready  = (state == IDLE) || last_stop;
    assign busy      = !tx_ready;
    assign tx_done   = last_stop;
    assign handshake = tx_valid && tx_ready;

`ifdef UART_TX_BREAK_EN
    logic                 break_start;
    logic [BIT_CNT_W-1:0] break_last;

    assign break_start = (state == IDLE) && !handshake && send_break;
    // Two frame times in bit periods, minus one: 2*(DATA_BITS+2) - 1 plus 2 per optional bit.
    assign break_last  = BIT_CNT_W'(2 * DATA_BITS + 3)
                       + ((par_mode_q != PAR_NONE) ? BIT_CNT_W'(2) : '0)
                       + (two_stop_q ? BIT_CNT_W'(2) : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_nxt = START;
                end
`ifdef UART_TX_BREAK_EN
                else if (send_break) begin
                    state_nxt = BREAK;
                end
`endif
            end
            START: begin
                tx = 1'b0;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                tx = shreg[0];
                if (tick && data_last) state_nxt = (par_mode_q != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: begin
                tx = par_bit;
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (last_stop) state_nxt = handshake ? START : IDLE;
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                tx = 1'b0;
                if (tick && bit_cnt == break_last) state_nxt = STOP;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            par_bit    <= 1'b0;
        end else if (handshake) begin
            shreg      <= tx_data;
            bit_cnt    <= '0;
            par_mode_q <= parity_t'(parity_mode);
            two_stop_q <= two_stop;
            par_bit    <= calc_parity(MAX_DATA_BITS'(tx_data), parity_t'(parity_mode));
        end
`ifdef UART_TX_BREAK_EN
        else if (break_start) begin
            bit_cnt    <= '0;
            par_mode_q <= parity_t'(parity_mode);
            two_stop_q <= two_stop;
        end
`endif
        else if (tick) begin
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            if (state == DATA) begin
                shreg <= shreg >> 1;
            end
`ifdef UART_TX_BREAK_EN
            // The trailing mark after a break is always a single bit period.
            if (state == BREAK && state_nxt == STOP) begin
                two_stop_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at BAUD_WIDTH=10 (8-bit and 5-bit instances).
module tb_uart_tx_cfg;

    localparam int BW = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid8 = 1'b0, tx_valid5 = 1'b0;
    logic [1:0] parity_mode = '0;
    logic       two_stop = 1'b0;
    logic       send_break = 1'b0;
    logic       tx8, ready8, busy8, done8;
    logic       tx5, ready5, busy5, done5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid8), .tx_ready(ready8),
        .parity_mode(parity_mode), .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
        .send_break(send_break),
`endif
        .tx(tx8), .busy(busy8), .tx_done(done8)
    );

    uart_tx_cfg #(.CLOCK_SPEED(1000), .BAUD_RATE(100), .DATA_BITS(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[4:0]), .tx_valid(tx_valid5), .tx_ready(ready5),
        .parity_mode(parity_mode), .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .tx(tx5), .busy(busy5), .tx_done(done5)
    );

    typedef struct {
        logic        sel;     // 0: 8-bit instance, 1: 5-bit instance
        logic [7:0]  data;
        logic [1:0]  pmode;
        logic        ts;
        logic        brk;
        logic [11:0] frame;   // line level per bit period, start bit in bit 0
        int          cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int   bad_tx = 0, bad_ctl = 0, bad_done = 0;
        logic s_tx, s_rdy, s_busy, s_done;
        @(negedge clk);
        tx_data     = v.data;
        parity_mode = v.pmode;
        two_stop    = v.ts;
        send_break  = v.brk;
        if (v.sel) tx_valid5 = 1'b1;
        else       tx_valid8 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid5   = 1'b0;
        tx_valid8   = 1'b0;
        send_break  = 1'b0;
        tx_data     = ~tx_data;
        parity_mode = ~parity_mode;
        two_stop    = ~two_stop;
        for (int k = 1; k <= v.cycles; k++) begin
            @(negedge clk);
            s_tx   = v.sel ? tx5   : tx8;
            s_rdy  = v.sel ? ready5 : ready8;
            s_busy = v.sel ? busy5 : busy8;
            s_done = v.sel ? done5 : done8;
            if (s_tx !== v.frame[(k-1)/BW]) bad_tx++;
            if (k < v.cycles) begin
                if (s_rdy !== 1'b0 || s_busy !== 1'b1 || s_done !== 1'b0) bad_ctl++;
            end else begin
                if (s_rdy !== 1'b1 || s_busy !== 1'b0 || s_done !== 1'b1) bad_done++;
            end
        end
        @(negedge clk);
        s_tx   = v.sel ? tx5   : tx8;
        s_rdy  = v.sel ? ready5 : ready8;
        s_done = v.sel ? done5 : done8;
        check({tag, "_tx_bits"}, bad_tx, 0);
        check({tag, "_ctl"}, bad_ctl, 0);
        check({tag, "_done"}, bad_done, 0);
        check({tag, "_idle_after"}, {s_done, s_tx, s_rdy}, 3'b011);
    endtask

    initial begin
        logic [9:0] f1, f2;
        int         bad_tx, bad_ctl, done_seen;
        logic       exp_tx;

        vecs.push_back('{1'b0, 8'hA5, 2'b00, 1'b0, 1'b0, 12'({1'b1, 8'hA5, 1'b0}), 100});
        vecs.push_back('{1'b0, 8'h03, 2'b01, 1'b0, 1'b0, 12'({1'b1, 1'b1, 8'h03, 1'b0}), 110});
        vecs.push_back('{1'b0, 8'h03, 2'b10, 1'b0, 1'b0, 12'({1'b1, 1'b0, 8'h03, 1'b0}), 110});
        vecs.push_back('{1'b0, 8'h03, 2'b11, 1'b0, 1'b0, 12'({1'b1, 1'b1, 8'h03, 1'b0}), 110});
        vecs.push_back('{1'b1, 8'h1F, 2'b10, 1'b1, 1'b0, 12'({2'b11, 1'b1, 5'h1F, 1'b0}), 90});
        vecs.push_back('{1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 12'({2'b11, 1'b0, 8'h00, 1'b0}), 120});
        vecs.push_back('{1'b0, 8'h80, 2'b01, 1'b0, 1'b0, 12'({1'b1, 1'b0, 8'h80, 1'b0}), 110});
        vecs.push_back('{1'b1, 8'h0A, 2'b00, 1'b0, 1'b0, 12'({1'b1, 5'h0A, 1'b0}), 70});
`ifdef UART_TX_BREAK_EN
        // handshake and send_break together: the data frame wins
        vecs.push_back('{1'b0, 8'hA5, 2'b00, 1'b0, 1'b1, 12'({1'b1, 8'hA5, 1'b0}), 100});
`endif

        repeat (3) @(negedge clk);
        check("rst_tx", tx8, 1'b1);
        check("rst_ready", ready8, 1'b1);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: tx_valid held, data changed mid-frame, next start right after tx_done.
        f1 = {1'b1, 8'h55, 1'b0};
        f2 = {1'b1, 8'h0F, 1'b0};
        bad_tx = 0;
        bad_ctl = 0;
        @(negedge clk);
        tx_data = 8'h55;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        tx_valid8 = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            exp_tx = (k <= 100) ? f1[(k-1)/BW] : f2[(k-101)/BW];
            if (tx8 !== exp_tx) bad_tx++;
            if (k == 100 || k == 200) begin
                if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b1) bad_ctl++;
            end else begin
                if (ready8 !== 1'b0 || busy8 !== 1'b1 || done8 !== 1'b0) bad_ctl++;
            end
            if (k == 50)  tx_data = 8'h0F;
            if (k == 101) tx_valid8 = 1'b0;
        end
        check("b2b_tx_bits", bad_tx, 0);
        check("b2b_ctl", bad_ctl, 0);
        @(negedge clk);
        check("b2b_idle_after", {done8, tx8, ready8}, 3'b011);

        // Asynchronous reset in the middle of the data bits.
        @(negedge clk);
        tx_data = 8'hA5;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        tx_valid8 = 1'b1;
        @(posedge clk);
        #1 tx_valid8 = 1'b0;
        repeat (37) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx8, 1'b1);
        check("midrst_ready", ready8, 1'b1);
        check("midrst_busy", busy8, 1'b0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done8 !== 1'b0 || tx8 !== 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_frame(vecs[0], "post_rst");

`ifdef UART_TX_BREAK_EN
        // Break with 8N1: 200 cycles low, 10 high, tx_done on the last high cycle.
        bad_tx = 0;
        bad_ctl = 0;
        @(negedge clk);
        parity_mode = 2'b00;
        two_stop = 1'b0;
        send_break = 1'b1;
        @(posedge clk);
        #1 send_break = 1'b0;
        for (int k = 1; k <= 210; k++) begin
            @(negedge clk);
            if (tx8 !== ((k <= 200) ? 1'b0 : 1'b1)) bad_tx++;
            if (k == 210) begin
                if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b1) bad_ctl++;
            end else begin
                if (ready8 !== 1'b0 || busy8 !== 1'b1 || done8 !== 1'b0) bad_ctl++;
            end
        end
        check("break_tx", bad_tx, 0);
        check("break_ctl", bad_ctl, 0);
        @(negedge clk);
        check("break_idle_after", {done8, tx8, ready8}, 3'b011);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
